// File: rtl/i2s_tx.sv
// Mono I2S transmitter: one 16-bit sample is sent on both 32-bit channel slots
// of a free-running 64-bclk frame. A one-entry holding register absorbs rate mismatch.
module i2s_tx #(
  parameter int BCLK_HALF = 18
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] sample_in,
  input  logic        sample_in_valid,
  input  logic        clear_flags,
  output logic        sample_req,
  output logic        underrun,
  output logic        overrun,
  output logic        i2s_bclk,
  output logic        i2s_lrclk,
  output logic        i2s_sdata
);

  localparam int DW = (BCLK_HALF > 1) ? $clog2(BCLK_HALF) : 1;
  localparam logic [DW-1:0] DIV_MAX = DW'(BCLK_HALF - 1);

  logic [DW-1:0] div_cnt_q;
  logic          bclk_q, lrclk_q, sdata_q;
  logic [5:0]    b_q;
  logic [15:0]   hold_q, tx_q;
  logic          new_q, req_q, under_q, over_q;

  logic          tick, fall, load;
  logic [5:0]    b_d;
  logic          lrclk_d, sdata_d;

  always_comb begin
    tick    = (div_cnt_q == DIV_MAX);
    fall    = tick & bclk_q;
    b_d     = b_q + 6'd1;
    load    = fall & (b_d == 6'd63);
    lrclk_d = (b_d >= 6'd31) && (b_d <= 6'd62);
    // Both data windows (0..15, 32..47) have b[4]=0; bit index is 15-b[3:0].
    sdata_d = (b_d[4] == 1'b0) ? tx_q[~b_d[3:0]] : 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_cnt_q <= '0;
      bclk_q    <= 1'b0;
      b_q       <= 6'd63;
      lrclk_q   <= 1'b0;
      sdata_q   <= 1'b0;
      hold_q    <= '0;
      new_q     <= 1'b0;
      tx_q      <= '0;
      req_q     <= 1'b0;
      under_q   <= 1'b0;
      over_q    <= 1'b0;
    end else begin
      div_cnt_q <= tick ? '0 : div_cnt_q + DW'(1);
      if (tick) bclk_q <= ~bclk_q;
      if (fall) begin
        b_q     <= b_d;
        lrclk_q <= lrclk_d;
        sdata_q <= sdata_d;
      end
      req_q <= load;
      if (load) tx_q <= hold_q;
      // An incoming sample always lands after a same-cycle load has consumed hold.
      if (sample_in_valid) begin
        hold_q <= sample_in;
        new_q  <= 1'b1;
      end else if (load) begin
        new_q  <= 1'b0;
      end
      if (clear_flags) begin
        under_q <= 1'b0;
        over_q  <= 1'b0;
      end
      if (load && !new_q) under_q <= 1'b1;
      if (sample_in_valid && new_q && !load) over_q <= 1'b1;
    end
  end

  assign sample_req = req_q;
  assign underrun   = under_q;
  assign overrun    = over_q;
  assign i2s_bclk   = bclk_q;
  assign i2s_lrclk  = lrclk_q;
  assign i2s_sdata  = sdata_q;

endmodule

// File: doc/i2s_tx.md
Name: i2s_tx

Overview:
- Mono I2S transmitter: the consumer end of the 16-bit sample / one-cycle valid-pulse stream produced by the effects chain.
- Sits after the last effect stage. Drives the external stereo DAC with bclk, lrclk and sdata.
- Each incoming sample is placed on both channels.
- The frame clock runs free and is not locked to the sample strobe. A one-entry holding register absorbs rate mismatch by repeating or dropping samples, and each event is flagged.

Parameters:
- BCLK_HALF, 18, clk cycles per bclk half-period (must be ≥2); frame = 64 bclk = 128*BCLK_HALF clk.

Ports:
- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-high
- sample_in  in  16  signed PCM sample
- sample_in_valid  in  1  one-cycle strobe; sample_in captured this cycle
- clear_flags  in  1  synchronous clear of underrun/overrun
- sample_req  out  1  one-cycle pulse when the holding register is consumed
- underrun  out  1  sticky: a frame started with no new sample (last word repeated)
- overrun  out  1  sticky: a sample was overwritten before being consumed
- i2s_bclk  out  1  serial bit clock
- i2s_lrclk  out  1  word select; 0 = left, 1 = right
- i2s_sdata  out  1  serial data

Behaviour:
- Reset (async, rst high):
  - div_cnt=0, bclk=0, bit index b=63, lrclk=0, sdata=0.
  - hold=0, new=0, tx_word=0, sample_req=0, underrun=0, overrun=0.
- Divider:
  - div_cnt counts 0..BCLK_HALF-1. At BCLK_HALF-1 it wraps and bclk toggles, registered.
  - A falling event is a toggle 1→0. b advances (63 wraps to 0) on each falling event.
- Registered outputs change only on falling events, in the same cycle bclk goes low. Values for the new index b:
  - lrclk = 1 for b in 31..62; lrclk = 0 for b = 63 and b in 0..30.
  - sdata = tx_word[15-b] for b in 0..15.
  - sdata = tx_word[15-(b-32)] for b in 32..47.
  - sdata = 0 otherwise.
  - Each channel is a 32-bit slot: MSB-first, left-justified one bclk after the lrclk edge (standard I2S), zero-padded.
- Load: on the falling event entering b=63 (lrclk falling):
  - tx_word <= hold.
  - sample_req pulses high for exactly that one cycle.
  - If new=1: clear new. If new=0: set underrun; tx_word gets hold, which equals the previous word (repeat).
- Capture: on sample_in_valid:
  - hold <= sample_in, new <= 1.
  - If new was already 1 and no load occurs this cycle: set overrun; the older sample is lost.
- Simultaneous load and sample_in_valid:
  - The load uses pre-cycle hold/new.
  - The incoming sample then lands in hold with new=1.
  - No overrun, and no underrun if pre-cycle new=1.
- First frame after reset:
  - The first falling event enters b=0, so frame 0 transmits tx_word=0.
  - The first load occurs at its end. underrun sets there if no sample has arrived.
- Flags:
  - Sticky until clear_flags=1.
  - On a cycle where clear_flags=1 and a set condition coincide, the set wins.
- Other timing:
  - Input is accepted every cycle; there is no backpressure.
  - Latency from capture to first sdata bit is up to one frame plus one bclk.
- Reset mid-frame aborts immediately; outputs return to reset values asynchronously.
- Widths: sample_in is passed bit-exact; no arithmetic on data.
- Design size: counters are 6-bit b plus $clog2(BCLK_HALF)-bit div_cnt.

Test Plan:
- Reset → all outputs 0. With BCLK_HALF=2:
  - bclk period = 4 clk.
  - First bclk rise at clk 2 after reset release.
  - Frame = 256 clk.
  - Frame 0 sdata all 0.
  - underrun=1 after the first load with no input.
- Send 0xA5C3 once before the first load → next frame: left slot b0..15 = 1010010111000011, right slot identical; b16..31 and b48..63 zeros. lrclk low for b=63 and b=0..30, high for b=31..62.
- Send one sample per frame, each timed mid-frame: 0x8000, 0x7FFF, 0x0001 → transmitted in order one frame later each; sample_req is one pulse per frame; underrun and overrun stay 0 after clear_flags.
- Send 0x1111 then 0x2222 within one frame → 0x2222 transmitted, overrun=1. Next frame has no input → 0x2222 repeated, underrun=1. clear_flags → both 0.
- Assert sample_in_valid with 0x3333 on the exact sample_req cycle while new=0 → underrun=1, overrun=0; 0x3333 is transmitted in the following frame.
- Assert rst at b=40 mid-frame → bclk/lrclk/sdata drop to 0 the same cycle. After release, timing restarts as after power-up with tx_word=0.
